// File: rtl/regfile_2w_sb.sv
// regfile_2w_sb: dual-write register file with per-register busy scoreboard and optional write-to-read bypass
module regfile_2w_sb #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic [ADDR_W-1:0]     raddr1,
  input  logic [ADDR_W-1:0]     raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  output logic [2**ADDR_W-1:0]  busy_vec
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic wc0, wc1, rc;
  logic [DEPTH-1:0] wmask, rmask;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic rb [2];
  // port 1 is dropped on an address clash so port 0 wins without ordering tricks
  assign wc0 = !rst && we0 && !(ZERO_REG0 != 0 && waddr0 == '0);
  assign wc1 = !rst && we1 && !(ZERO_REG0 != 0 && waddr1 == '0) && !(we0 && waddr0 == waddr1);
  assign rc  = !rst && rsv_en && !(ZERO_REG0 != 0 && rsv_addr == '0);
  assign wmask = (wc0 ? DEPTH'(1) << waddr0 : '0) | (wc1 ? DEPTH'(1) << waddr1 : '0);
  assign rmask = rc ? DEPTH'(1) << rsv_addr : '0;
  assign ra[0] = raddr1;
  assign ra[1] = raddr2;
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit0, hit1;
    assign hit0 = wc0 && waddr0 == ra[p];
    assign hit1 = wc1 && waddr1 == ra[p];
    assign rd[p] = (ZERO_REG0 != 0 && ra[p] == '0) ? '0 :
                   (BYPASS != 0 && hit0) ? wdata0 :
                   (BYPASS != 0 && hit1) ? wdata1 : regs[ra[p]];
    assign rb[p] = (BYPASS != 0 && (hit0 || hit1) && !(rc && rsv_addr == ra[p])) ? 1'b0 : busy_vec[ra[p]];
  end
  assign rdata1 = rd[0];
  assign rdata2 = rd[1];
  assign rbusy1 = rb[0];
  assign rbusy2 = rb[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy_vec <= '0;
    end else begin
      if (wc0) regs[waddr0] <= wdata0;
      if (wc1) regs[waddr1] <= wdata1;
      busy_vec <= (busy_vec & ~wmask) | rmask;
    end
  end
endmodule

// File: tb/tb_regfile_2w_sb.sv
// tb_regfile_2w_sb: three parameterisations driven in lockstep, scoreboarded against a behavioural model
module tb_regfile_2w_sb;
  logic clk = 0, rst = 0;
  logic we0 = 0, we1 = 0, rsv_en = 0;
  logic [2:0] waddr0 = 0, waddr1 = 0, rsv_addr = 0, raddr1 = 0, raddr2 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic [7:0] rd1 [3], rd2 [3], bv [3];
  logic rb1 [3], rb2 [3];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  regfile_2w_sb #(.BYPASS(1), .ZERO_REG0(0)) u_def (.clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1[0]), .rdata2(rd2[0]), .rbusy1(rb1[0]), .rbusy2(rb2[0]), .busy_vec(bv[0]));
  regfile_2w_sb #(.BYPASS(0), .ZERO_REG0(0)) u_nobp (.clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1[1]), .rdata2(rd2[1]), .rbusy1(rb1[1]), .rbusy2(rb2[1]), .busy_vec(bv[1]));
  regfile_2w_sb #(.BYPASS(1), .ZERO_REG0(1)) u_zero (.clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1[2]), .rdata2(rd2[2]), .rbusy1(rb1[2]), .rbusy2(rb2[2]), .busy_vec(bv[2]));

  typedef struct packed {
    logic [2:0][7:0] d1, d2, bv;
    logic [2:0] b1, b2;
  } exp_t;
  exp_t q[$];
  logic [7:0] mm [3][8];
  logic bz [3][8];
  bit init = 0;
  bit bp [3] = '{1, 0, 1};
  bit zr [3] = '{0, 0, 1};

  function automatic logic [7:0] m_rd(int c, logic [2:0] a);
    if (zr[c] && a == 0) return 8'h00;
    if (bp[c] && !rst && we0 && waddr0 == a) return wdata0;
    if (bp[c] && !rst && we1 && waddr1 == a) return wdata1;
    return mm[c][a];
  endfunction

  function automatic logic m_rb(int c, logic [2:0] a);
    logic wr, rs;
    wr = !rst && ((we0 && waddr0 == a) || (we1 && waddr1 == a)) && !(zr[c] && a == 0);
    rs = !rst && rsv_en && rsv_addr == a && !(zr[c] && a == 0);
    return (bp[c] && wr && !rs) ? 1'b0 : bz[c][a];
  endfunction

  task automatic cyc(input logic r, input logic e0, input logic [2:0] a0, input logic [7:0] d0,
                     input logic e1, input logic [2:0] a1, input logic [7:0] d1,
                     input logic rs, input logic [2:0] ra, input logic [2:0] x1, input logic [2:0] x2);
    exp_t e;
    @(posedge clk); #1;
    rst = r; we0 = e0; waddr0 = a0; wdata0 = d0; we1 = e1; waddr1 = a1; wdata1 = d1;
    rsv_en = rs; rsv_addr = ra; raddr1 = x1; raddr2 = x2;
    if (init) begin
      for (int c = 0; c < 3; c++) begin
        e.d1[c] = m_rd(c, x1); e.d2[c] = m_rd(c, x2);
        e.b1[c] = m_rb(c, x1); e.b2[c] = m_rb(c, x2);
        for (int i = 0; i < 8; i++) e.bv[c][i] = bz[c][i];
      end
      q.push_back(e);
    end
    // state the coming edge will leave behind
    for (int c = 0; c < 3; c++) begin
      if (r) begin
        for (int i = 0; i < 8; i++) begin mm[c][i] = 0; bz[c][i] = 0; end
      end else begin
        if (e1 && !(zr[c] && a1 == 0)) begin mm[c][a1] = d1; bz[c][a1] = 0; end
        if (e0 && !(zr[c] && a0 == 0)) begin mm[c][a0] = d0; bz[c][a0] = 0; end
        if (rs && !(zr[c] && ra == 0)) bz[c][ra] = 1;
      end
    end
    if (r) init = 1;
  endtask

  task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d t=%0t got=%h expected=%h", nm, c, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int c = 0; c < 3; c++) begin
        chk("rdata1", c, rd1[c], e.d1[c]);
        chk("rdata2", c, rd2[c], e.d2[c]);
        chk("rbusy1", c, {7'd0, rb1[c]}, {7'd0, e.b1[c]});
        chk("rbusy2", c, {7'd0, rb2[c]}, {7'd0, e.b2[c]});
        chk("busy_vec", c, bv[c], e.bv[c]);
      end
    end
  end

  initial begin
    cyc(1, 0,0,0, 0,0,0, 0,0, 0,0);
    cyc(0, 1,1,8'hAA, 0,0,0, 0,0, 1,2);
    cyc(0, 1,2,8'h55, 0,0,0, 0,0, 1,2);
    cyc(0, 0,0,0, 0,0,0, 0,0, 1,2);
    cyc(0, 1,3,8'h11, 1,3,8'h22, 0,0, 3,3);
    cyc(0, 0,0,0, 0,0,0, 0,0, 3,3);
    cyc(0, 1,4,8'h33, 1,5,8'h44, 0,0, 4,5);
    cyc(0, 0,0,0, 0,0,0, 0,0, 4,5);
    cyc(0, 1,6,8'h5A, 0,0,0, 0,0, 6,6);
    cyc(0, 0,0,0, 0,0,0, 0,0, 6,1);
    cyc(0, 0,0,0, 0,0,0, 1,2, 2,2);
    cyc(0, 0,0,0, 0,0,0, 0,0, 2,2);
    cyc(0, 0,0,0, 1,2,8'h77, 0,0, 2,2);
    cyc(0, 0,0,0, 0,0,0, 0,0, 2,2);
    cyc(0, 1,2,8'h66, 0,0,0, 1,2, 2,2);
    cyc(0, 0,0,0, 0,0,0, 0,0, 2,2);
    for (int i = 0; i < 8; i++) cyc(0, 1,3'(i),8'hFF, 0,0,0, 0,0, 3'(i),7);
    cyc(0, 0,0,0, 0,0,0, 1,7, 7,0);
    cyc(1, 1,1,8'hAA, 0,0,0, 1,3, 1,7);
    for (int i = 0; i < 8; i++) cyc(0, 0,0,0, 0,0,0, 0,0, 3'(i),3'(7-i));
    cyc(0, 1,0,8'hFF, 0,0,0, 1,0, 0,0);
    cyc(0, 0,0,0, 0,0,0, 0,0, 0,0);
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(31) == 0, 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
          $urandom_range(3) == 0, 3'($urandom), 3'($urandom), 3'($urandom));
    cyc(0, 0,0,0, 0,0,0, 0,0, 0,0);
    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_2w_sb.md
REGFILE_2W_SB -- requirements
Module: regfile_2w_sb

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled (0 = disabled).
REQ-004 The block SHALL have parameter ZERO_REG0, default 0, meaning register 0 is hardwired to zero when set to 1.

Interface
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 we0 / waddr0 / wdata0  input  1 / ADDR_W / DATA_W  write port 0 (ALU writeback).
REQ-008 we1 / waddr1 / wdata1  input  1 / ADDR_W / DATA_W  write port 1 (load writeback).
REQ-009 rsv_en / rsv_addr  input  1 / ADDR_W  scoreboard reserve request (marks register busy).
REQ-010 raddr1, raddr2  input  ADDR_W each  read addresses.
REQ-011 rdata1, rdata2  output  DATA_W each  read data, combinational from raddr.
REQ-012 rbusy1, rbusy2  output  1 each  busy flag of the addressed register.
REQ-013 busy_vec  output  DEPTH  registered busy bit per register; bit i = register i.

Function
REQ-014 Writes SHALL commit at the rising edge of clk when weN=1 and rst=0; one-cycle latency to the stored value.
REQ-015 When we0=1 and we1=1 target the same address, port 0 SHALL win; port 1 data is discarded.
REQ-016 When we0=1 and we1=1 target different addresses, both writes SHALL commit in the same cycle.
REQ-017 Reads SHALL be asynchronous: rdata = stored value of raddr, with no clock latency.
REQ-018 With BYPASS=1, if raddrN equals a write address active this cycle, rdataN SHALL return the winning write data (port 0 over port 1).
REQ-019 With BYPASS=0, rdataN SHALL return the pre-edge stored value during a same-cycle write.
REQ-020 Both read ports SHALL be independent; raddr1 == raddr2 SHALL return identical data and busy.
REQ-021 A committed write to register i SHALL clear busy bit i at that edge.
REQ-022 rsv_en=1 SHALL set busy bit rsv_addr at the edge.
REQ-023 Reserve and write to the same address in the same cycle: busy SHALL end at 1 and the data SHALL still commit.
REQ-024 rbusyN SHALL equal busy_vec[raddrN].
REQ-025 With BYPASS=1, rbusyN SHALL read 0 when raddrN is being written this cycle and not reserved this cycle.
REQ-026 With ZERO_REG0=1, writes and reserves to address 0 SHALL be ignored, reads of address 0 SHALL return 0, and busy_vec[0] SHALL stay 0.
REQ-027 Address wrap SHALL NOT occur: every ADDR_W value is a valid register.

Reset
REQ-028 At a rising edge with rst=1, all registers SHALL become 0 and busy_vec SHALL become all 0.
REQ-029 While rst=1, writes and reserves SHALL be ignored, including those asserted on the same edge.
REQ-030 Reset asserted mid-sequence SHALL discard any pending reservation; rdata and rbusy SHALL reflect the cleared state on the cycle after the edge.
REQ-031 The block SHALL have no asynchronous reset path; the state before the first reset edge is undefined.

Verification (DATA_W=8, ADDR_W=3, BYPASS=1, ZERO_REG0=0 unless stated)
REQ-032 Basic scenario: reset, then we0 writes reg1=AA and then reg2=55, then both writes are deasserted with raddr1=1 and raddr2=2 -> rdata1=AA, rdata2=55.
REQ-033 Dual-write scenario: we0 writes reg3=11 and we1 writes reg3=22 in the same cycle -> reg3=11; we0 writes reg4=33 and we1 writes reg5=44 in the same cycle -> both values stored.
REQ-034 Bypass scenario: we0 writes reg6=5A with raddr1=6 in the same cycle -> rdata1=5A before the edge; with BYPASS=0 the same stimulus -> old value before the edge and 5A after the edge.
REQ-035 Scoreboard scenario: reserve reg2 -> busy_vec=04 and rbusy=1; then we1 writes reg2=77 -> busy cleared; reserve and write reg2 in the same cycle -> busy stays 1 and data=stored value.
REQ-036 Reset-during-operation scenario: fill regs with FF and reserve reg7, then assert rst together with we0 writing reg1=AA -> all rdata=00 and busy_vec=00.
REQ-037 Zero-register scenario (ZERO_REG0=1): write reg0=FF and reserve reg0 -> rdata=00 and busy_vec[0]=0.
